// File: rtl/hamming_interleaver_stream_if.sv
// Handshake bundle for the codeword-in / interleaved-block-out stream.
// The flush signal exists only when INTERLEAVER_FLUSH_EN is defined.
interface hamming_interleaver_stream_if #(
   parameter int unsigned ROWS = 4,
   parameter int unsigned COLS = 15
);
   localparam int unsigned BW = ROWS * COLS;
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic [COLS-1:0] cw_data;
   logic            cw_valid;
   logic            cw_ready;
   logic [BW-1:0]   blk_data;
   logic            blk_valid;
   logic            blk_ready;
   logic [RW-1:0]   row_idx;

`ifdef INTERLEAVER_FLUSH_EN
   logic            flush;

   modport master (
      output cw_data, cw_valid, blk_ready, flush,
      input  cw_ready, blk_data, blk_valid, row_idx
   );
   modport slave (
      input  cw_data, cw_valid, blk_ready, flush,
      output cw_ready, blk_data, blk_valid, row_idx
   );
`else
   modport master (
      output cw_data, cw_valid, blk_ready,
      input  cw_ready, blk_data, blk_valid, row_idx
   );
   modport slave (
      input  cw_data, cw_valid, blk_ready,
      output cw_ready, blk_data, blk_valid, row_idx
   );
`endif
endinterface

// File: rtl/hamming_interleaver_stream.sv
// Ping-pong block interleaver: ROWS codewords in, one column-major block of ROWS*COLS bits out.
// Optional partial-block flush enabled by defining INTERLEAVER_FLUSH_EN.
module hamming_interleaver_stream #(
   parameter int unsigned ROWS = 4,
   parameter int unsigned COLS = 15
) (
   input  logic                      clk,
   input  logic                      rst_n,
   hamming_interleaver_stream_if.slave bus
);
   localparam int unsigned BW = ROWS * COLS;
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
   // Banks are stored already interleaved: row r occupies bits ROWS*c+r.
   localparam logic [BW-1:0] ROW0_MASK = {COLS{ROWS'(1)}};

   logic [BW-1:0] bank_q [2];
   logic [BW-1:0] bank_d [2];
   logic [1:0]    full_q, full_d;
   logic          wr_sel_q, wr_sel_d;
   logic          rd_sel_q, rd_sel_d;
   logic [RW-1:0] row_q, row_d;
   logic          cw_ready_q;
   logic          blk_valid_q;
   logic [BW-1:0] blk_data_q;

   logic [BW-1:0] spread_c;
   logic [BW-1:0] mask_c;
   logic [BW-1:0] base_c;
   logic          accept_c, drain_c, flush_c, close_c;

   // Each codeword bit c is replicated across its column; the row mask picks one slot.
   for (genvar c = 0; c < COLS; c++) begin : g_spread
      assign spread_c[ROWS*c +: ROWS] = {ROWS{bus.cw_data[c]}};
   end

   always_comb begin
      bank_d   = bank_q;
      full_d   = full_q;
      wr_sel_d = wr_sel_q;
      rd_sel_d = rd_sel_q;
      row_d    = row_q;
      mask_c   = ROW0_MASK << row_q;
      base_c   = (row_q == '0) ? '0 : bank_q[wr_sel_q];
      accept_c = bus.cw_valid && cw_ready_q;
      drain_c  = blk_valid_q && bus.blk_ready;
`ifdef INTERLEAVER_FLUSH_EN
      flush_c  = bus.flush && cw_ready_q && ((row_q != '0) || accept_c);
`else
      flush_c  = 1'b0;
`endif

      // First row clears the bank, so unwritten rows of a flushed block read as zero.
      if (accept_c) begin
         bank_d[wr_sel_q] = (base_c & ~mask_c) | (spread_c & mask_c);
         row_d            = row_q + RW'(1);
      end

      close_c = (accept_c && (row_q == LAST_ROW)) || flush_c;
      if (close_c) begin
         full_d[wr_sel_q] = 1'b1;
         wr_sel_d         = !wr_sel_q;
         row_d            = '0;
      end

      // Close and drain always hit different banks, so both may apply in one cycle.
      if (drain_c) begin
         full_d[rd_sel_q] = 1'b0;
         rd_sel_d         = !rd_sel_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q[0]   <= '0;
         bank_q[1]   <= '0;
         full_q      <= '0;
         wr_sel_q    <= 1'b0;
         rd_sel_q    <= 1'b0;
         row_q       <= '0;
         cw_ready_q  <= 1'b1;
         blk_valid_q <= 1'b0;
         blk_data_q  <= '0;
      end else begin
         bank_q      <= bank_d;
         full_q      <= full_d;
         wr_sel_q    <= wr_sel_d;
         rd_sel_q    <= rd_sel_d;
         row_q       <= row_d;
         cw_ready_q  <= !full_d[wr_sel_d];
         blk_valid_q <= full_d[rd_sel_d];
         blk_data_q  <= full_d[rd_sel_d] ? bank_d[rd_sel_d] : '0;
      end
   end

   assign bus.cw_ready  = cw_ready_q;
   assign bus.blk_valid = blk_valid_q;
   assign bus.blk_data  = blk_data_q;
   assign bus.row_idx   = row_q;

endmodule

// File: tb/tb_hamming_interleaver_stream.sv
// Directed and randomized bench for hamming_interleaver_stream against a queue-based block model.
module tb_hamming_interleaver_stream;
   localparam int unsigned ROWS = 4;
   localparam int unsigned COLS = 15;
   localparam int unsigned BW   = ROWS * COLS;
`ifdef INTERLEAVER_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hamming_interleaver_stream_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
   hamming_interleaver_stream #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_tests   = 0;
   int n_fail    = 0;
   int n_drained = 0;

   // Model: codewords accepted and not yet drained, oldest first; last `part` are the open block.
   logic [COLS-1:0] rows_q [$];
   int              part = 0;

   logic          obs_ready, obs_valid;
   logic [BW-1:0] obs_data;
   logic [1:0]    obs_row;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] interleave_front();
      logic [BW-1:0] blk;
      blk = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            blk[ROWS*c + r] = rows_q[r][c];
      return blk;
   endfunction

   function automatic logic [COLS-1:0] deinterleave_row(input logic [BW-1:0] blk, input int r);
      logic [COLS-1:0] row;
      for (int c = 0; c < COLS; c++) row[c] = blk[ROWS*c + r];
      return row;
   endfunction

   // One cycle: drive inputs at the falling edge, check registered outputs, advance the model.
   task automatic step(input logic v, input logic [COLS-1:0] d, input logic rdy, input logic fl);
      int            complete;
      bit            exp_ready, exp_valid;
      logic [BW-1:0] exp_data;
      @(negedge clk);
      bus.cw_valid  = v;
      bus.cw_data   = d;
      bus.blk_ready = rdy;
`ifdef INTERLEAVER_FLUSH_EN
      bus.flush     = fl;
`endif
      obs_ready = bus.cw_ready;
      obs_valid = bus.blk_valid;
      obs_data  = bus.blk_data;
      obs_row   = bus.row_idx;

      complete  = (rows_q.size() - part) / ROWS;
      exp_ready = (complete < 2);
      exp_valid = (complete > 0);
      exp_data  = exp_valid ? interleave_front() : '0;
      check("cw_ready", 64'(obs_ready), 64'(exp_ready));
      check("blk_valid", 64'(obs_valid), 64'(exp_valid));
      check("row_idx", 64'(obs_row), 64'(part));
      check("blk_data", 64'(obs_data), 64'(exp_data));

      if (exp_valid && rdy) begin
         for (int r = 0; r < ROWS; r++)
            check("recovered_row", 64'(deinterleave_row(obs_data, r)), 64'(rows_q[r]));
         for (int r = 0; r < ROWS; r++) void'(rows_q.pop_front());
         n_drained++;
      end
      if (v && exp_ready) begin
         rows_q.push_back(d);
         part++;
      end
      if (FLUSH_EN && fl && exp_ready && (part != 0)) begin
         while (part < ROWS) begin
            rows_q.push_back('0);
            part++;
         end
      end
      if (part == ROWS) part = 0;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_cw_ready"}, 64'(bus.cw_ready), 64'(1));
      check({tag, "_blk_valid"}, 64'(bus.blk_valid), 64'(0));
      check({tag, "_blk_data"}, 64'(bus.blk_data), 64'(0));
      check({tag, "_row_idx"}, 64'(bus.row_idx), 64'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n         = 1'b0;
      bus.cw_valid  = 1'b0;
      bus.blk_ready = 1'b0;
`ifdef INTERLEAVER_FLUSH_EN
      bus.flush     = 1'b0;
`endif
      #1;
      reset_checks("midrst");
      rows_q.delete();
      part = 0;
      @(negedge clk);
      reset_checks("midrst_hold");
      rst_n = 1'b1;
   endtask

   initial begin
      int cyc;
      int target;
      logic [COLS-1:0] d9;

      bus.cw_valid  = 1'b0;
      bus.cw_data   = '0;
      bus.blk_ready = 1'b0;
`ifdef INTERLEAVER_FLUSH_EN
      bus.flush     = 1'b0;
`endif
      #12;
      reset_checks("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Single-row pattern and one-cycle valid pulse.
      step(1'b1, 15'h7FFF, 1'b1, 1'b0);
      step(1'b1, 15'h0000, 1'b1, 1'b0);
      step(1'b1, 15'h0000, 1'b1, 1'b0);
      step(1'b1, 15'h0000, 1'b1, 1'b0);
      step(1'b0, 15'h0000, 1'b1, 1'b0);
      check("t1_valid", 64'(obs_valid), 64'(1));
      check("t1_data", 64'(obs_data), 64'(60'h111111111111111));
      step(1'b0, 15'h0000, 1'b1, 1'b0);
      check("t1_single_cycle", 64'(obs_valid), 64'(0));

      // Back-to-back blocks.
      step(1'b1, 15'h0000, 1'b1, 1'b0);
      step(1'b1, 15'h7FFF, 1'b1, 1'b0);
      step(1'b1, 15'h0000, 1'b1, 1'b0);
      step(1'b1, 15'h0000, 1'b1, 1'b0);
      step(1'b1, 15'h0001, 1'b1, 1'b0);
      check("t2a_data", 64'(obs_data), 64'(60'h222222222222222));
      step(1'b1, 15'h0002, 1'b1, 1'b0);
      step(1'b1, 15'h0004, 1'b1, 1'b0);
      step(1'b1, 15'h0008, 1'b1, 1'b0);
      step(1'b0, 15'h0000, 1'b1, 1'b0);
      check("t2b_data", 64'(obs_data), 64'(60'h000000000008421));

      // Both banks full: ninth codeword stalls until the first drain.
      for (int i = 0; i < 8; i++) step(1'b1, COLS'($urandom), 1'b0, 1'b0);
      d9 = COLS'($urandom);
      step(1'b1, d9, 1'b0, 1'b0);
      check("t3_stall_ready", 64'(obs_ready), 64'(0));
      check("t3_stall_row", 64'(obs_row), 64'(0));
      step(1'b1, d9, 1'b1, 1'b0);
      check("t3_still_stalled", 64'(obs_ready), 64'(0));
      step(1'b1, d9, 1'b1, 1'b0);
      check("t3_resume_ready", 64'(obs_ready), 64'(1));
      step(1'b0, 15'h0000, 1'b1, 1'b0);
      check("t3_ninth_accepted", 64'(obs_row), 64'(1));
      check("t3_all_drained", 64'(obs_valid), 64'(0));

      // Reset mid-block discards the partial block.
      step(1'b1, 15'h7FFF, 1'b1, 1'b0);
      do_reset();
      step(1'b1, 15'h0000, 1'b1, 1'b0);
      step(1'b1, 15'h0000, 1'b1, 1'b0);
      step(1'b1, 15'h7FFF, 1'b1, 1'b0);
      step(1'b1, 15'h0000, 1'b1, 1'b0);
      step(1'b0, 15'h0000, 1'b1, 1'b0);
      check("t4_valid", 64'(obs_valid), 64'(1));
      check("t4_data", 64'(obs_data), 64'(60'h444444444444444));
      step(1'b0, 15'h0000, 1'b1, 1'b0);
      check("t4_no_extra", 64'(obs_valid), 64'(0));

`ifdef INTERLEAVER_FLUSH_EN
      step(1'b1, 15'h7FFF, 1'b1, 1'b0);
      step(1'b1, 15'h7FFF, 1'b1, 1'b0);
      step(1'b0, 15'h0000, 1'b1, 1'b1);
      step(1'b0, 15'h0000, 1'b1, 1'b0);
      check("t5_flush_valid", 64'(obs_valid), 64'(1));
      check("t5_flush_data", 64'(obs_data), 64'(60'h333333333333333));
      step(1'b0, 15'h0000, 1'b1, 1'b1);
      step(1'b0, 15'h0000, 1'b1, 1'b0);
      check("t5_idle_flush", 64'(obs_valid), 64'(0));
      check("t5_idle_row", 64'(obs_row), 64'(0));
`endif

      // Randomized traffic; every drained block is deinterleaved and compared row by row.
      cyc    = 0;
      target = n_drained + 1000;
      while ((n_drained < target) && (cyc < 60000)) begin
         step($urandom_range(0, 99) < 70, COLS'($urandom), $urandom_range(0, 99) < 60,
              FLUSH_EN && ($urandom_range(0, 99) < 3));
         cyc++;
      end
      check("t6_blocks_drained", 64'(n_drained >= target), 64'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
